load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 64, meaning the number of cycles ACCESS waits for mem_ack before a fault.
REQ-002 The block SHALL use clock clk and reset reset, asynchronous, active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  asynchronous active-high reset.
REQ-005 start  in  1  one-cycle issue pulse; sampled only in IDLE.
REQ-006 is_store  in  1  1 = store, 0 = load.
REQ-007 funct3  in  3  RV32I width/sign code (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010).
REQ-008 base  in  32  rs1 value.
REQ-009 offset  in  32  sign-extended immediate.
REQ-010 store_data  in  32  rs2 value.
REQ-011 rd  in  5  load destination register.
REQ-012 busy  out  1  high whenever state is not IDLE.
REQ-013 mem_req, mem_we  out  1 each  memory request and write-enable.
REQ-014 mem_addr  out  32  word-aligned address, bits [1:0] = 00.
REQ-015 mem_wdata  out  32, mem_be  out  4  lane-replicated store data and byte enables.
REQ-016 mem_ack  in  1, mem_rdata  in  32  memory acknowledge and read word, valid in the ack cycle.
REQ-017 wb_valid  out  1, wb_rd  out  5, wb_data  out  32  register-file writeback.
REQ-018 fault  out  1, fault_addr  out  32  one-cycle error pulse and offending effective address.

Function
REQ-019 Effective address ea SHALL equal base + offset, modulo 2^32; it SHALL be latched with all other inputs in the start cycle.
REQ-020 States SHALL be IDLE, ACCESS, RESP and FAULT.
REQ-021 IDLE with start=1 SHALL go to FAULT when the access is bad, otherwise to ACCESS.
REQ-022 An access SHALL be bad when funct3 is illegal for its direction, or when it is a halfword with ea[0]=1, or a word with ea[1:0]!=00.
REQ-023 start while busy=1 SHALL be ignored, with no queuing.
REQ-024 In ACCESS, mem_req SHALL be 1 and mem_addr, mem_we, mem_wdata and mem_be SHALL stay constant until the cycle mem_ack=1; the access completes in that cycle.
REQ-025 mem_ack while mem_req=0 SHALL be ignored.
REQ-026 Store lanes: SB SHALL drive wdata={4{sd[7:0]}} and be=0001<<ea[1:0]; SH SHALL drive wdata={2{sd[15:0]}} and be=0011 or 1100 by ea[1]; SW SHALL drive be=1111. Loads SHALL drive be=1111 and mem_we=0.
REQ-027 A load ack SHALL capture mem_rdata, select the lane by ea[1:0], sign-extend LB/LH, zero-extend LBU/LHU, then go to RESP.
REQ-028 RESP SHALL assert wb_valid for exactly one cycle with wb_rd=rd and return to IDLE.
REQ-029 A store ack SHALL return directly to IDLE with no wb_valid.
REQ-030 A load with rd=0 SHALL complete the memory access but keep wb_valid=0 in RESP.
REQ-031 Load latency: start at cycle 0, mem_req at cycle 1, and with ack at cycle 1, wb_valid at cycle 2.
REQ-032 Store latency: start at cycle 0 and ack at cycle 1 leave busy=0 at cycle 2.
REQ-033 ACCESS SHALL count cycles without ack; on reaching TIMEOUT it SHALL drop mem_req and go to FAULT.
REQ-034 FAULT SHALL pulse fault=1 for one cycle with fault_addr=ea, issue no memory write and no wb_valid, then return to IDLE.
REQ-035 wb_data and fault_addr SHALL hold their last values when their qualifiers are low.

Reset
REQ-036 Asserting reset SHALL immediately force state IDLE and clear the timeout counter.
REQ-037 Asserting reset SHALL immediately drive busy, mem_req, mem_we, mem_be, wb_valid and fault to 0, and mem_addr, mem_wdata, wb_rd, wb_data and fault_addr to 0.
REQ-038 A transaction in progress at reset SHALL be abandoned with no writeback or fault.

Verification
REQ-039 LB, base=0x100, offset=3, mem_rdata=0x80FF_1234, ack immediately -> mem_addr=0x100; wb_data=0xFFFF_FF80 and wb_valid at cycle 2.
REQ-040 SH, base=0x200, offset=2, store_data=0x0000_BEEF -> mem_we=1, mem_be=1100, mem_wdata=0xBEEF_BEEF, no wb_valid.
REQ-041 LW with ea=0x102 -> fault pulse at cycle 1 with fault_addr=0x102; mem_req never asserts.
REQ-042 LHU with ack delayed 5 cycles and start pulsed during the wait -> outputs stable while waiting, the second start is ignored, one wb_valid only.
REQ-043 No ack with TIMEOUT=4 -> mem_req high 4 cycles, then fault=1.
REQ-044 Reset in ACCESS -> mem_req and busy drop at once, and no wb_valid or fault follows.

Source files
------------

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one outstanding access, lane steering, load extension,
// misalignment/illegal-code faults and an ack timeout.
module load_store_unit #(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        is_store,
   input  logic [2:0]  funct3,
   input  logic [31:0] base,
   input  logic [31:0] offset,
   input  logic [31:0] store_data,
   input  logic [4:0]  rd,
   output logic        busy,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        fault,
   output logic [31:0] fault_addr
);

   localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP, FAULT} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [31:0]   ea_q, ea_nxt;
   logic          store_q, store_nxt;
   logic [2:0]    f3_q, f3_nxt;
   logic [4:0]    rd_q, rd_nxt;

   logic          busy_nxt, req_nxt, we_nxt, wbv_nxt, fault_nxt;
   logic [31:0]   addr_nxt, wdata_nxt, wbdata_nxt, faddr_nxt;
   logic [3:0]    be_nxt;
   logic [4:0]    wbrd_nxt;

   logic [31:0]   ea_c, st_wdata_c, ld_shift_c, ld_data_c;
   logic [15:0]   ld_half_c;
   logic [3:0]    st_be_c;
   logic          legal_c, misaligned_c, bad_c;

   // Issue-time decode on the live inputs
   always_comb begin
      ea_c = base + offset;
      if (is_store) legal_c = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
      else          legal_c = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                              (funct3 == 3'b100) || (funct3 == 3'b101);
      misaligned_c = ((funct3[1:0] == 2'b01) && ea_c[0]) ||
                     ((funct3[1:0] == 2'b10) && (ea_c[1:0] != 2'b00));
      bad_c = !legal_c || misaligned_c;
      case (funct3)
         3'b000: begin
            st_wdata_c = {4{store_data[7:0]}};
            st_be_c    = 4'b0001 << ea_c[1:0];
         end
         3'b001: begin
            st_wdata_c = {2{store_data[15:0]}};
            st_be_c    = ea_c[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            st_wdata_c = store_data;
            st_be_c    = 4'b1111;
         end
      endcase
   end

   // Load lane select and extension against the latched access
   always_comb begin
      ld_shift_c = mem_rdata >> {ea_q[1:0], 3'b000};
      ld_half_c  = ea_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (f3_q)
         3'b000:  ld_data_c = {{24{ld_shift_c[7]}}, ld_shift_c[7:0]};
         3'b100:  ld_data_c = {24'h0, ld_shift_c[7:0]};
         3'b001:  ld_data_c = {{16{ld_half_c[15]}}, ld_half_c};
         3'b101:  ld_data_c = {16'h0, ld_half_c};
         default: ld_data_c = mem_rdata;
      endcase
   end

   // Next state and next registered outputs
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      ea_nxt     = ea_q;
      store_nxt  = store_q;
      f3_nxt     = f3_q;
      rd_nxt     = rd_q;
      req_nxt    = 1'b0;
      we_nxt     = 1'b0;
      addr_nxt   = mem_addr;
      wdata_nxt  = mem_wdata;
      be_nxt     = mem_be;
      wbv_nxt    = 1'b0;
      wbrd_nxt   = wb_rd;
      wbdata_nxt = wb_data;
      fault_nxt  = 1'b0;
      faddr_nxt  = fault_addr;
      case (state)
         IDLE: begin
            if (start) begin
               ea_nxt    = ea_c;
               store_nxt = is_store;
               f3_nxt    = funct3;
               rd_nxt    = rd;
               cnt_nxt   = '0;
               if (bad_c) begin
                  state_nxt = FAULT;
                  fault_nxt = 1'b1;
                  faddr_nxt = ea_c;
               end else begin
                  state_nxt = ACCESS;
                  req_nxt   = 1'b1;
                  we_nxt    = is_store;
                  addr_nxt  = {ea_c[31:2], 2'b00};
                  wdata_nxt = is_store ? st_wdata_c : 32'h0;
                  be_nxt    = is_store ? st_be_c : 4'b1111;
               end
            end
         end
         ACCESS: begin
            if (mem_ack) begin
               if (store_q) begin
                  state_nxt = IDLE;
               end else begin
                  state_nxt = RESP;
                  // rd=0 loads finish silently and leave the writeback bus untouched
                  if (rd_q != 5'd0) begin
                     wbv_nxt    = 1'b1;
                     wbrd_nxt   = rd_q;
                     wbdata_nxt = ld_data_c;
                  end
               end
            end else if (cnt == CW'(TIMEOUT - 1)) begin
               state_nxt = FAULT;
               fault_nxt = 1'b1;
               faddr_nxt = ea_q;
            end else begin
               cnt_nxt = cnt + CW'(1);
               req_nxt = 1'b1;
               we_nxt  = store_q;
            end
         end
         RESP:    state_nxt = IDLE;
         FAULT:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      busy_nxt = (state_nxt != IDLE);
   end

   // State and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         ea_q       <= 32'h0;
         store_q    <= 1'b0;
         f3_q       <= 3'b000;
         rd_q       <= 5'd0;
         busy       <= 1'b0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= 32'h0;
         mem_wdata  <= 32'h0;
         mem_be     <= 4'h0;
         wb_valid   <= 1'b0;
         wb_rd      <= 5'd0;
         wb_data    <= 32'h0;
         fault      <= 1'b0;
         fault_addr <= 32'h0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         ea_q       <= ea_nxt;
         store_q    <= store_nxt;
         f3_q       <= f3_nxt;
         rd_q       <= rd_nxt;
         busy       <= busy_nxt;
         mem_req    <= req_nxt;
         mem_we     <= we_nxt;
         mem_addr   <= addr_nxt;
         mem_wdata  <= wdata_nxt;
         mem_be     <= be_nxt;
         wb_valid   <= wbv_nxt;
         wb_rd      <= wbrd_nxt;
         wb_data    <= wbdata_nxt;
         fault      <= fault_nxt;
         fault_addr <= faddr_nxt;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: transaction-level model with per-cycle compare,
// plus literal checks of latency, lanes, faults, timeout and reset.
module tb_load_store_unit;

   localparam int unsigned T_MAIN  = 8;
   localparam int unsigned T_SHORT = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        start, is_store, mem_ack;
   logic [2:0]  funct3;
   logic [31:0] base, offset, store_data, mem_rdata;
   logic [4:0]  rd;

   logic        busy, mem_req, mem_we, wb_valid, fault;
   logic [31:0] mem_addr, mem_wdata, wb_data, fault_addr;
   logic [3:0]  mem_be;
   logic [4:0]  wb_rd;

   logic        busy_s, mem_req_s, mem_we_s, wb_valid_s, fault_s;
   logic [31:0] mem_addr_s, mem_wdata_s, wb_data_s, fault_addr_s;
   logic [3:0]  mem_be_s;
   logic [4:0]  wb_rd_s;

   load_store_unit #(.TIMEOUT(T_MAIN)) dut (
      .clk(clk), .reset(reset), .start(start), .is_store(is_store), .funct3(funct3),
      .base(base), .offset(offset), .store_data(store_data), .rd(rd), .busy(busy),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .wb_valid(wb_valid),
      .wb_rd(wb_rd), .wb_data(wb_data), .fault(fault), .fault_addr(fault_addr));

   load_store_unit #(.TIMEOUT(T_SHORT)) dut_short (
      .clk(clk), .reset(reset), .start(start), .is_store(is_store), .funct3(funct3),
      .base(base), .offset(offset), .store_data(store_data), .rd(rd), .busy(busy_s),
      .mem_req(mem_req_s), .mem_we(mem_we_s), .mem_addr(mem_addr_s), .mem_wdata(mem_wdata_s),
      .mem_be(mem_be_s), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .wb_valid(wb_valid_s),
      .wb_rd(wb_rd_s), .wb_data(wb_data_s), .fault(fault_s), .fault_addr(fault_addr_s));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: access size, legality, byte-lane placement and load extension
   function automatic int unsigned nbytes(input logic [2:0] f3);
      return 1 << f3[1:0];
   endfunction

   function automatic bit m_bad(input bit st, input logic [2:0] f3, input logic [31:0] ea);
      bit legal;
      legal = st ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 <= 3'd5);
      return !legal || ((ea % nbytes(f3)) != 0);
   endfunction

   function automatic logic [3:0] m_be(input bit st, input logic [2:0] f3, input logic [31:0] ea);
      if (!st) return 4'hF;
      return 4'(((1 << nbytes(f3)) - 1) << (ea % 4));
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
      logic [31:0] w;
      for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % nbytes(f3)) +: 8];
      return w;
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] ea,
                                          input logic [31:0] rdata);
      logic [63:0] mask;
      logic [31:0] v;
      int unsigned n;
      n    = nbytes(f3);
      mask = (64'd1 << (8 * n)) - 64'd1;
      v    = (rdata >> (8 * (ea % 4))) & mask[31:0];
      if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~mask[31:0];
      return v;
   endfunction

   // Expected memory request and outcome queues
   bit          req_exp = 1'b0;
   logic [31:0] r_addr, r_wdata;
   logic [3:0]  r_be;
   logic        r_we;
   logic [4:0]  wbrd_q[$];
   logic [31:0] wbdat_q[$];
   logic [31:0] flt_q[$];
   logic [31:0] last_wb = 32'h0;
   logic [31:0] last_fa = 32'h0;
   logic [31:0] e_data;
   logic [4:0]  e_rd;
   bit          cmp_en = 1'b0;
   int          wb_pulses = 0;
   int          fault_pulses = 0;

   always @(negedge clk) begin
      if (cmp_en && !reset) begin
         if (mem_req) begin
            check("req_expected", 32'(req_exp), 32'd1);
            if (req_exp) begin
               check("mem_addr", mem_addr, r_addr);
               check("mem_we", 32'(mem_we), 32'(r_we));
               check("mem_be", 32'(mem_be), 32'(r_be));
               if (r_we) check("mem_wdata", mem_wdata, r_wdata);
            end
         end
         if (wb_valid) begin
            wb_pulses++;
            if (wbdat_q.size() == 0) check("wb_unexpected", 32'(wb_valid), 32'd0);
            else begin
               e_data = wbdat_q.pop_front();
               e_rd   = wbrd_q.pop_front();
               check("wb_rd", 32'(wb_rd), 32'(e_rd));
               check("wb_data", wb_data, e_data);
               last_wb = e_data;
            end
         end else check("wb_data_hold", wb_data, last_wb);
         if (fault) begin
            fault_pulses++;
            check("fault_no_write", 32'(mem_we), 32'd0);
            if (flt_q.size() == 0) check("fault_unexpected", 32'(fault), 32'd0);
            else begin
               e_data = flt_q.pop_front();
               check("fault_addr", fault_addr, e_data);
               last_fa = e_data;
            end
         end else check("fault_addr_hold", fault_addr, last_fa);
      end
   end

   // Observations from the most recent transaction (cycle 1 and completion cycle)
   logic        s_req1, s_we1, s_fault1, s_busy2, s_wbv2;
   logic [31:0] s_addr1, s_wdata1, s_faddr1, s_wbdata2;
   logic [3:0]  s_be1;

   task automatic wait_idle();
      for (int i = 0; i < 40 && busy; i++) begin
         @(posedge clk); #1;
      end
      check("return_idle", 32'(busy), 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic txn(input bit st, input logic [2:0] f3, input logic [31:0] b, input logic [31:0] off,
                      input logic [31:0] sd, input logic [4:0] r, input int delay,
                      input logic [31:0] rdata, input bit poke);
      logic [31:0] ea;
      bit bad;
      ea  = b + off;
      bad = m_bad(st, f3, ea);
      @(posedge clk); #1;
      start = 1'b1; is_store = st; funct3 = f3; base = b; offset = off; store_data = sd; rd = r;
      if (bad) flt_q.push_back(ea);
      else begin
         r_addr = ea & ~32'h3; r_we = st; r_be = m_be(st, f3, ea); r_wdata = m_wdata(f3, sd);
         req_exp = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      s_req1 = mem_req; s_we1 = mem_we; s_addr1 = mem_addr; s_wdata1 = mem_wdata; s_be1 = mem_be;
      s_fault1 = fault; s_faddr1 = fault_addr;
      if (!bad) begin
         for (int k = 0; k <= delay; k++) begin
            mem_ack   = (k == delay);
            mem_rdata = (k == delay) ? rdata : (32'hDEAD_0000 | 32'(k));
            if (poke && k == 1) begin
               start = 1'b1; is_store = ~st; funct3 = 3'b010; base = 32'h400; offset = 32'h0;
               store_data = 32'hFFFF_FFFF; rd = 5'd7;
            end
            @(posedge clk); #1;
            start = 1'b0; mem_ack = 1'b0;
         end
         req_exp = 1'b0;
         if (!st && r != 5'd0) begin
            wbrd_q.push_back(r);
            wbdat_q.push_back(m_load(f3, ea, rdata));
         end
         s_busy2 = busy; s_wbv2 = wb_valid; s_wbdata2 = wb_data;
      end
      wait_idle();
   endtask

   int p0, f0, n_short, fc_short;
   logic main_fault9;

   initial begin
      reset = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'b000; base = 32'h0; offset = 32'h0;
      store_data = 32'h0; rd = 5'd0; mem_ack = 1'b0; mem_rdata = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_mem_be", 32'(mem_be), 32'd0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_wb_valid", 32'(wb_valid), 32'd0);
      check("rst_wb_rd", 32'(wb_rd), 32'd0);
      check("rst_fault", 32'(fault), 32'd0);
      check("rst_fault_addr", fault_addr, 32'h0);
      reset = 1'b0;
      cmp_en = 1'b1;

      // LB sign extension, ack in the first access cycle
      txn(1'b0, 3'b000, 32'h100, 32'h3, 32'h0, 5'd5, 0, 32'h80FF_1234, 1'b0);
      check("lb_req_c1", 32'(s_req1), 32'd1);
      check("lb_addr_c1", s_addr1, 32'h100);
      check("lb_wbv_c2", 32'(s_wbv2), 32'd1);
      check("lb_wbdata_c2", s_wbdata2, 32'hFFFF_FF80);

      // SH upper half: lanes and no writeback
      p0 = wb_pulses;
      txn(1'b1, 3'b001, 32'h200, 32'h2, 32'h0000_BEEF, 5'd6, 0, 32'h0, 1'b0);
      check("sh_we", 32'(s_we1), 32'd1);
      check("sh_be", 32'(s_be1), 32'hC);
      check("sh_wdata", s_wdata1, 32'hBEEF_BEEF);
      check("sh_busy_c2", 32'(s_busy2), 32'd0);
      check("sh_no_wb", 32'(wb_pulses - p0), 32'd0);

      // Misaligned LW faults in cycle 1 without a request
      txn(1'b0, 3'b010, 32'h100, 32'h2, 32'h0, 5'd1, 0, 32'h0, 1'b0);
      check("lw_mis_fault_c1", 32'(s_fault1), 32'd1);
      check("lw_mis_faddr", s_faddr1, 32'h102);
      check("lw_mis_no_req", 32'(s_req1), 32'd0);

      // LHU with late ack and an ignored second start
      p0 = wb_pulses;
      txn(1'b0, 3'b101, 32'h300, 32'h6, 32'h0, 5'd9, 5, 32'hA5B6_C7D8, 1'b1);
      check("lhu_one_wb", 32'(wb_pulses - p0), 32'd1);
      check("lhu_data", wb_data, 32'h0000_A5B6);

      // Further lanes, extensions, wrap-around, rd=0 and illegal codes
      txn(1'b0, 3'b001, 32'h200, 32'h2, 32'h0, 5'd10, 1, 32'h8001_7FFF, 1'b0);
      check("lh_data", wb_data, 32'hFFFF_8001);
      txn(1'b0, 3'b100, 32'h100, 32'h1, 32'h0, 5'd11, 0, 32'h1234_F0AB, 1'b0);
      check("lbu_data", wb_data, 32'h0000_00F0);
      txn(1'b0, 3'b000, 32'h104, 32'hFFFF_FFFE, 32'h0, 5'd12, 2, 32'h0012_7F00, 1'b0);
      txn(1'b1, 3'b000, 32'h200, 32'h3, 32'h1234_565A, 5'd0, 0, 32'h0, 1'b0);
      check("sb_be", 32'(s_be1), 32'h8);
      check("sb_wdata", s_wdata1, 32'h5A5A_5A5A);
      txn(1'b1, 3'b010, 32'h8, 32'h8, 32'h0123_4567, 5'd0, 3, 32'h0, 1'b0);
      txn(1'b0, 3'b010, 32'hFFFF_FFFC, 32'h8, 32'h0, 5'd13, 0, 32'hCAFE_F00D, 1'b0);
      check("wrap_addr", s_addr1, 32'h4);
      p0 = wb_pulses;
      txn(1'b0, 3'b010, 32'h40, 32'h0, 32'h0, 5'd0, 0, 32'h1111_1111, 1'b0);
      check("rd0_no_wb", 32'(wb_pulses - p0), 32'd0);
      txn(1'b1, 3'b100, 32'h40, 32'h0, 32'h0, 5'd0, 0, 32'h0, 1'b0);
      txn(1'b0, 3'b011, 32'h40, 32'h0, 32'h0, 5'd2, 0, 32'h0, 1'b0);
      txn(1'b1, 3'b001, 32'h41, 32'h0, 32'h0, 5'd0, 0, 32'h0, 1'b0);

      // Timeout: short instance faults after 4 request cycles, main after 8
      @(posedge clk); #1;
      start = 1'b1; is_store = 1'b0; funct3 = 3'b010; base = 32'h300; offset = 32'h0; rd = 5'd3;
      r_addr = 32'h300; r_we = 1'b0; r_be = 4'hF; r_wdata = 32'h0; req_exp = 1'b1;
      flt_q.push_back(32'h300);
      @(posedge clk); #1;
      start = 1'b0;
      n_short = 0; fc_short = -1; main_fault9 = 1'b0;
      for (int c = 1; c <= 9; c++) begin
         if (c == 9) begin
            req_exp = 1'b0;
            main_fault9 = fault;
         end
         if (mem_req_s) n_short++;
         if (fault_s && fc_short < 0) begin
            fc_short = c;
            check("to_short_faddr", fault_addr_s, 32'h300);
         end
         if (c < 9) begin
            @(posedge clk); #1;
         end
      end
      check("to_short_req_cycles", 32'(n_short), 32'd4);
      check("to_short_fault_cycle", 32'(fc_short), 32'd5);
      check("to_main_fault_c9", 32'(main_fault9), 32'd1);
      wait_idle();

      // Reset during ACCESS abandons the transaction
      p0 = wb_pulses; f0 = fault_pulses;
      @(posedge clk); #1;
      start = 1'b1; is_store = 1'b0; funct3 = 3'b010; base = 32'h500; offset = 32'h0; rd = 5'd4;
      r_addr = 32'h500; r_we = 1'b0; r_be = 4'hF; req_exp = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("rst_acc_req_before", 32'(mem_req), 32'd1);
      #3 reset = 1'b1;
      #1;
      check("rst_acc_req", 32'(mem_req), 32'd0);
      check("rst_acc_busy", 32'(busy), 32'd0);
      check("rst_acc_addr", mem_addr, 32'h0);
      check("rst_acc_wb_data", wb_data, 32'h0);
      req_exp = 1'b0; last_wb = 32'h0; last_fa = 32'h0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      check("rst_acc_no_wb", 32'(wb_pulses - p0), 32'd0);
      check("rst_acc_no_fault", 32'(fault_pulses - f0), 32'd0);
      check("rst_acc_idle", 32'(busy), 32'd0);
      check("queues_drained", 32'(wbdat_q.size() + flt_q.size()), 32'd0);

      cmp_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
